mod3_seq_checker: RTL and testbench



---
 rtl/mod3_seq_checker.sv | 135 +++++++++++++
 tb/tb_mod3_seq_checker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mod3_seq_checker.sv
// Lock monitor for the mod-MODULUS count stream; flags sequence and range errors.
// Optional STICKY_ERR_EN adds err_sticky/clr_sticky.
module mod3_seq_checker #(
  parameter int MODULUS  = 3,
  parameter int CW       = 2,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CW-1:0]     count_in,
`ifdef STICKY_ERR_EN
  input  logic              clr_sticky,
  output logic              err_sticky,
`endif
  output logic              locked,
  output logic [CW-1:0]     expected,
  output logic              seq_err,
  output logic              illegal_val,
  output logic              wrap_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [WRAP_W-1:0] wrap_count
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] MAX  = CW'(MODULUS - 1);
  localparam logic [CW:0]   MODV = (CW+1)'(MODULUS);
  localparam logic [MW-1:0] LAST = MW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] prev_q, prev_d;
  logic [CW-1:0] exp_d;
  logic [MW-1:0] match_q, match_d;
  logic          seq_d, ill_d, wrap_d;
  logic          err_inc, legal;

  // Compare-and-clear increment so non-power-of-two moduli work.
  function automatic logic [CW-1:0] inc(input logic [CW-1:0] v);
    return (v == MAX) ? '0 : v + CW'(1);
  endfunction

  assign legal = {1'b0, count_in} < MODV;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    exp_d   = expected;
    seq_d   = 1'b0;
    ill_d   = 1'b0;
    wrap_d  = 1'b0;
    err_inc = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        ill_d   = 1'b1;
        err_inc = 1'b1;
        state_d = HUNT;
      end else begin
        prev_d = count_in;
        exp_d  = inc(count_in);
        unique case (state_q)
          HUNT: begin
            match_d = '0;
            state_d = SYNC;
          end
          SYNC: begin
            if (count_in == inc(prev_q)) begin
              match_d = match_q + MW'(1);
              if (match_q == LAST)
                state_d = LOCKED;
            end else begin
              match_d = '0;
            end
          end
          LOCKED: begin
            if (count_in == expected) begin
              wrap_d = (prev_q == MAX) && (count_in == '0);
            end else begin
              seq_d   = 1'b1;
              err_inc = 1'b1;
              match_d = '0;
              state_d = SYNC;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      prev_q      <= '0;
      match_q     <= '0;
      locked      <= 1'b0;
      expected    <= '0;
      seq_err     <= 1'b0;
      illegal_val <= 1'b0;
      wrap_pulse  <= 1'b0;
      err_count   <= '0;
      wrap_count  <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      locked      <= (state_d == LOCKED);
      expected    <= exp_d;
      seq_err     <= seq_d;
      illegal_val <= ill_d;
      wrap_pulse  <= wrap_d;
      if (err_inc && (err_count != '1))
        err_count <= err_count + ERR_W'(1);
      if (wrap_d)
        wrap_count <= wrap_count + WRAP_W'(1);
    end
  end

`ifdef STICKY_ERR_EN
  // A new error on the clearing edge keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst)
      err_sticky <= 1'b0;
    else if (err_inc)
      err_sticky <= 1'b1;
    else if (clr_sticky)
      err_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mod3_seq_checker.sv
// Directed bench for mod3_seq_checker; a second instance uses ERR_W=2.
module tb_mod3_seq_checker;

  logic       clk = 1'b0;
  logic       rst, in_valid;
  logic [1:0] count_in;
  logic       locked, seq_err, illegal_val, wrap_pulse;
  logic [1:0] expected;
  logic [7:0] err_count, wrap_count;
  logic       locked2, seq_err2, illegal_val2, wrap_pulse2;
  logic [1:0] expected2;
  logic [1:0] err_count2;
  logic [7:0] wrap_count2;
`ifdef STICKY_ERR_EN
  logic clr_sticky, err_sticky, err_sticky2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod3_seq_checker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in),
`ifdef STICKY_ERR_EN
    .clr_sticky(clr_sticky), .err_sticky(err_sticky),
`endif
    .locked(locked), .expected(expected), .seq_err(seq_err),
    .illegal_val(illegal_val), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  mod3_seq_checker #(.ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .count_in(count_in),
`ifdef STICKY_ERR_EN
    .clr_sticky(clr_sticky), .err_sticky(err_sticky2),
`endif
    .locked(locked2), .expected(expected2), .seq_err(seq_err2),
    .illegal_val(illegal_val2), .wrap_pulse(wrap_pulse2),
    .err_count(err_count2), .wrap_count(wrap_count2)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] c);
    @(negedge clk);
    in_valid = v;
    count_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string tag, input logic l, input logic s,
                       input logic i, input logic w);
    chk1({tag, ".locked"}, locked, l);
    chk1({tag, ".seq_err"}, seq_err, s);
    chk1({tag, ".illegal"}, illegal_val, i);
    chk1({tag, ".wrap"}, wrap_pulse, w);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    count_in = 2'd0;
`ifdef STICKY_ERR_EN
    clr_sticky = 1'b0;
`endif
    step(1'b0, 2'd0);
    step(1'b0, 2'd0);
    rst = 1'b0;
    flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk2("rst.expected", expected, 2'd0);
    chk8("rst.err_count", err_count, 8'd0);
    chk8("rst.wrap_count", wrap_count, 8'd0);

    // acquisition and first wrap
    step(1'b1, 2'd0);
    flags("t1.s0", 1'b0, 1'b0, 1'b0, 1'b0);
    chk2("t1.s0.exp", expected, 2'd1);
    step(1'b1, 2'd1);
    flags("t1.s1", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2);
    flags("t1.s2", 1'b1, 1'b0, 1'b0, 1'b0);
    chk2("t1.s2.exp", expected, 2'd0);
    step(1'b1, 2'd0);
    flags("t1.s3", 1'b1, 1'b0, 1'b0, 1'b1);
    chk8("t1.s3.wc", wrap_count, 8'd1);
    step(1'b1, 2'd1);
    flags("t1.s4", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2);
    chk8("t1.s5.wc", wrap_count, 8'd1);
    chk8("t1.s5.ec", err_count, 8'd0);

    // sequence error and relock
    step(1'b1, 2'd0);
    chk8("t2.wc", wrap_count, 8'd2);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd1);
    flags("t2.err", 1'b0, 1'b1, 1'b0, 1'b0);
    chk8("t2.err.ec", err_count, 8'd1);
    chk2("t2.err.exp", expected, 2'd2);
`ifdef STICKY_ERR_EN
    chk1("t2.sticky", err_sticky, 1'b1);
`endif
    step(1'b1, 2'd2);
    flags("t2.r2", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0);
    flags("t2.r0", 1'b1, 1'b0, 1'b0, 1'b0);
    chk8("t2.r0.wc", wrap_count, 8'd2);

    // illegal value, then relock across a valid gap
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd3);
    flags("t3.ill", 1'b0, 1'b0, 1'b1, 1'b0);
    chk8("t3.ill.ec", err_count, 8'd2);
    chk2("t3.ill.exp", expected, 2'd0);
    step(1'b1, 2'd0);
    flags("t3.h0", 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 2'd3);
      flags("t4.gap", 1'b0, 1'b0, 1'b0, 1'b0);
      chk2("t4.gap.exp", expected, 2'd2);
    end
    step(1'b1, 2'd2);
    flags("t4.lock", 1'b1, 1'b0, 1'b0, 1'b0);
    chk8("t4.lock.ec", err_count, 8'd2);
    step(1'b1, 2'd0);
    flags("t4.wrap", 1'b1, 1'b0, 1'b0, 1'b1);
    chk8("t4.wrap.wc", wrap_count, 8'd3);

    // saturation on the narrow instance
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 2'd3);
      chk1("t5.ill", illegal_val2, 1'b1);
      chk2("t5.ec2", err_count2, 2'd3);
      chk8("t5.ec", err_count, 8'(3 + k));
    end
    step(1'b0, 2'd0);
    chk1("t5.idle", illegal_val2, 1'b0);
    chk2("t5.idle.ec2", err_count2, 2'd3);

    // reset mid-stream, then relock
    step(1'b1, 2'd0);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    flags("t6.pre", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 2'd0);
    rst = 1'b0;
    flags("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk2("t6.rst.exp", expected, 2'd0);
    chk8("t6.rst.ec", err_count, 8'd0);
    chk8("t6.rst.wc", wrap_count, 8'd0);
    chk2("t6.rst.ec2", err_count2, 2'd0);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd0);
    flags("t6.lock", 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1);
    step(1'b1, 2'd2);
    step(1'b1, 2'd0);
    flags("t6.wrap", 1'b1, 1'b0, 1'b0, 1'b1);
    chk8("t6.wrap.wc", wrap_count, 8'd1);
`ifdef STICKY_ERR_EN
    chk1("t6.sticky0", err_sticky, 1'b0);
    clr_sticky = 1'b1;
    step(1'b1, 2'd2);
    chk1("t6.sticky_win", err_sticky, 1'b1);
    step(1'b0, 2'd0);
    chk1("t6.sticky_clr", err_sticky, 1'b0);
    clr_sticky = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
